elastic_pipe_reg: RTL and testbench
===================================

Name: elastic_pipe_reg

Overview:
- Parametrised elastic pipeline register with a valid/ready handshake, a 2-entry skid buffer and a synchronous flush.
- Replaces plain load/flush pipeline registers between DRAC stages (e.g. fetch->decode, decode->rename) where back-pressure must propagate without a combinational ready path.
- Sustains full throughput (1 item/cycle) with 1-cycle latency.
- Flush kills every in-flight item.

Parameters:
- WIDTH, 32, payload width in bits.
- RESET_VAL, '0 (WIDTH bits), value driven on data_o after reset or flush.

Ports:
- clk_i  input  1  clock; all state updates on rising edge.
- rst_i  input  1  asynchronous, active-high reset.
- flush_i  input  1  synchronous flush; discards all stored and incoming items.
- valid_i  input  1  upstream item valid.
- ready_o  output  1  block can accept an item; registered, depends only on state.
- data_i  input  WIDTH  upstream payload.
- valid_o  output  1  data_o holds a valid item.
- ready_i  input  1  downstream accepts data_o this cycle.
- data_o  output  WIDTH  head payload; driven directly from the main register.
- occupancy_o  output  2  number of items held (0..2).

Behaviour:
- Storage: main register (head, drives data_o) and skid register. State enum EMPTY, FULL, SKID.
- Transfer-in when valid_i & ready_o. Transfer-out when valid_o & ready_i.
- Outputs by state:
  - valid_o = (state != EMPTY).
  - ready_o = (state != SKID).
  - occupancy_o = 0 / 1 / 2 for EMPTY / FULL / SKID.
- Reset (rst_i=1, asynchronous): state=EMPTY, main=skid=RESET_VAL.
  - Output values under reset: valid_o=0, ready_o=1, data_o=RESET_VAL, occupancy_o=0.
  - Reset asserted mid-transfer drops all items immediately, with no partial update.
- Flush (priority over every handshake): next state EMPTY, main=skid=RESET_VAL.
  - An item presented with valid_i in the flush cycle is discarded, even though ready_o=1.
  - A transfer-out in the flush cycle still counts as consumed by downstream; no replay.
- Transitions (no flush):
  - EMPTY:
    - valid_i -> FULL, main<=data_i.
    - else stay.
  - FULL:
    - valid_i & ready_i -> FULL, main<=data_i (pass-through, full throughput).
    - valid_i & !ready_i -> SKID, skid<=data_i, main held.
    - !valid_i & ready_i -> EMPTY, main held (value stays, valid_o drops).
    - neither -> stay.
  - SKID:
    - ready_i -> FULL, main<=skid. valid_i is ignored because ready_o=0.
    - else stay, both registers held.
- Ordering: strict FIFO. Items never duplicated or dropped except by flush or reset.
- Latency: item accepted in cycle N appears on data_o/valid_o in cycle N+1.
- Stability: while valid_o=1 and ready_i=0, data_o and valid_o stay constant (AXI-style).
- No combinational path exists from ready_i or valid_i to ready_o.
- valid_i and data_i are ignored while ready_o=0; upstream is responsible for holding them.
- Payload is an opaque bit-vector of WIDTH bits.
- Assertions (sim only):
  - occupancy_o never exceeds 2.
  - data_o stable while valid_o & !ready_i.

Decomposition:
- drac_pkg gets:
  - typedef enum logic [1:0] {PIPE_EMPTY, PIPE_FULL, PIPE_SKID} pipe_state_t;
  - localparam PIPE_MAX_OCC = 2.
- Stage payload structs (e.g. fetch-out, decode-out) stay in drac_pkg. They are passed through as WIDTH=$bits(struct).
- No sub-module: the state register plus two data registers belong in one module.

Test Plan:
- Pass-through: reset, ready_i=1, drive valid_i=1 with data 0x11,0x22,0x33 on consecutive cycles -> data_o shows 0x11,0x22,0x33 one cycle later each; valid_o=1 throughout; ready_o=1; occupancy_o=1.
- Back-pressure/skid: FULL with 0xA, ready_i=0, push 0xB -> occupancy_o=2, ready_o=0, data_o=0xA held. Raise ready_i -> next cycle data_o=0xB, occupancy_o=1, then 0 with valid_o=0.
- Stall hold: state SKID, ready_i=0 for 10 cycles while data_i randomises -> data_o, valid_o, occupancy_o unchanged; no item lost after release (sequence 0xA,0xB).
- Flush: state SKID (0xA,0xB), flush_i=1 with valid_i=1, data_i=0xC -> next cycle valid_o=0, data_o=RESET_VAL(0), occupancy_o=0; 0xC never appears.
- Async reset mid-operation: SKID, assert rst_i between clock edges -> outputs go to valid_o=0, ready_o=1, data_o=0, occupancy_o=0 before the next edge. Deassert -> resumes accepting.
- Random stress (WIDTH=8 and WIDTH=64): 1000 cycles of random valid_i/ready_i -> scoreboard shows an in-order, lossless, duplicate-free stream; stability assertion never fires.

Source files
------------

// File: rtl/drac_pkg.sv
// drac_pkg: types and constants shared between the DRAC pipeline stages.
//   pipe_state_t   - state of an elastic pipeline register (EMPTY/FULL/SKID)
//   PIPE_MAX_OCC   - maximum number of items an elastic register can hold
//   fetch_out_t    - example stage payload, passed as WIDTH = $bits(fetch_out_t)
//   pipe_occupancy - maps a pipeline register state to its item count
package drac_pkg;

  typedef enum logic [1:0] {
    PIPE_EMPTY = 2'd0,
    PIPE_FULL  = 2'd1,
    PIPE_SKID  = 2'd2
  } pipe_state_t;

  localparam int unsigned PIPE_MAX_OCC = 2;

  // Fetch -> decode payload. The pipeline register treats it as opaque bits.
  typedef struct packed {
    logic [39:0] pc;
    logic [31:0] inst;
    logic        ex_valid;
  } fetch_out_t;

  function automatic logic [1:0] pipe_occupancy(input pipe_state_t s);
    case (s)
      PIPE_FULL: return 2'd1;
      PIPE_SKID: return 2'd2;
      default:   return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/elastic_pipe_reg.sv
// elastic_pipe_reg: elastic pipeline register with a valid/ready handshake,
// a 2-entry skid buffer and a synchronous flush. Full throughput, 1-cycle
// latency, and ready_o is a pure function of the registered state, so
// back-pressure never forms a combinational path through this block.
//
// Ports:
//   clk_i        clock, rising edge
//   rst_i        asynchronous active-high reset
//   flush_i      synchronous flush, drops all stored and incoming items
//   valid_i      upstream item valid
//   ready_o      block can accept an item (registered)
//   data_i       upstream payload, WIDTH bits
//   valid_o      data_o holds a valid item
//   ready_i      downstream accepts data_o this cycle
//   data_o       head payload, straight from the main register
//   occupancy_o  number of items held (0..2)
module elastic_pipe_reg
  import drac_pkg::*;
#(
  parameter int unsigned      WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] data_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] data_o,
  output logic [1:0]       occupancy_o
);

  pipe_state_t      state_reg, state_next;
  logic [WIDTH-1:0] main_reg,  main_next;
  logic [WIDTH-1:0] skid_reg,  skid_next;

  // State and data registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg <= PIPE_EMPTY;
      main_reg  <= RESET_VAL;
      skid_reg  <= RESET_VAL;
    end else begin
      state_reg <= state_next;
      main_reg  <= main_next;
      skid_reg  <= skid_next;
    end
  end

  // Next-state and next-data logic. Flush overrides every handshake; an
  // item leaving in the flush cycle is still considered consumed.
  always_comb begin
    state_next = state_reg;
    main_next  = main_reg;
    skid_next  = skid_reg;
    if (flush_i) begin
      state_next = PIPE_EMPTY;
      main_next  = RESET_VAL;
      skid_next  = RESET_VAL;
    end else begin
      case (state_reg)
        PIPE_EMPTY: begin
          if (valid_i) begin
            state_next = PIPE_FULL;
            main_next  = data_i;
          end
        end
        PIPE_FULL: begin
          case ({valid_i, ready_i})
            2'b11: main_next = data_i;        // pass-through
            2'b10: begin                      // downstream stalled: park in skid
              state_next = PIPE_SKID;
              skid_next  = data_i;
            end
            2'b01: state_next = PIPE_EMPTY;   // main keeps its stale value
            default: ;
          endcase
        end
        PIPE_SKID: begin
          // ready_o is low here, so valid_i is not looked at.
          if (ready_i) begin
            state_next = PIPE_FULL;
            main_next  = skid_reg;
          end
        end
        default: state_next = PIPE_EMPTY;
      endcase
    end
  end

  // Outputs depend on the registered state only.
  always_comb begin
    valid_o     = (state_reg != PIPE_EMPTY);
    ready_o     = (state_reg != PIPE_SKID);
    occupancy_o = pipe_occupancy(state_reg);
  end

  assign data_o = main_reg;

  // Simulation checks: occupancy bound and AXI-style hold under back-pressure.
  a_occ_bound : assert property (@(posedge clk_i) disable iff (rst_i)
    occupancy_o <= 2'(PIPE_MAX_OCC));

  a_hold_stable : assert property (@(posedge clk_i) disable iff (rst_i)
    (valid_o && !ready_i && !flush_i) |=> (valid_o && $stable(data_o)));

endmodule

// File: tb/tb_elastic_pipe_reg.sv
// Testbench for elastic_pipe_reg: directed scenarios followed by random
// stress, with WIDTH=8 and WIDTH=64 instances driven by the same handshake
// controls. Expected outputs come from a queue model of a 2-deep FIFO.
module tb_elastic_pipe_reg;
  import drac_pkg::*;

  logic        tb_clk_i;
  logic        rst_i;
  logic        flush_i;
  logic        valid_i;
  logic        ready_i;
  logic [7:0]  data8_i;
  logic [63:0] data64_i;

  logic        ready8_o, valid8_o;
  logic [7:0]  data8_o;
  logic [1:0]  occ8_o;
  logic        ready64_o, valid64_o;
  logic [63:0] data64_o;
  logic [1:0]  occ64_o;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: ordered item queues plus the value left on data_o
  // once the register has drained (last item handed downstream).
  logic [63:0] q8[$];
  logic [63:0] q64[$];
  logic [63:0] last8, last64;

  elastic_pipe_reg #(.WIDTH(8)) dut8 (
    .clk_i       (tb_clk_i),
    .rst_i       (rst_i),
    .flush_i     (flush_i),
    .valid_i     (valid_i),
    .ready_o     (ready8_o),
    .data_i      (data8_i),
    .valid_o     (valid8_o),
    .ready_i     (ready_i),
    .data_o      (data8_o),
    .occupancy_o (occ8_o)
  );

  elastic_pipe_reg #(.WIDTH(64)) dut64 (
    .clk_i       (tb_clk_i),
    .rst_i       (rst_i),
    .flush_i     (flush_i),
    .valid_i     (valid_i),
    .ready_o     (ready64_o),
    .data_i      (data64_i),
    .valid_o     (valid64_o),
    .ready_i     (ready_i),
    .data_o      (data64_o),
    .occupancy_o (occ64_o)
  );

  initial tb_clk_i = 1'b0;
  always #5 tb_clk_i = ~tb_clk_i;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    q8.delete();
    q64.delete();
    last8  = 64'h0;
    last64 = 64'h0;
  endtask

  // One clock edge of the reference FIFO, using the inputs present at it.
  task automatic model_edge();
    int  sz;
    bit  take_in, take_out;
    sz = q8.size();
    if (rst_i || flush_i) begin
      model_clear();
    end else begin
      take_out = (sz > 0) && ready_i;
      take_in  = valid_i && (sz < int'(PIPE_MAX_OCC));
      if (take_out) begin
        last8  = q8.pop_front();
        last64 = q64.pop_front();
      end
      if (take_in) begin
        q8.push_back({56'h0, data8_i});
        q64.push_back(data64_i);
      end
    end
  endtask

  task automatic check_model(input string tag);
    logic [63:0] exp8, exp64;
    int sz;
    sz    = q8.size();
    exp8  = (sz > 0) ? q8[0]  : last8;
    exp64 = (sz > 0) ? q64[0] : last64;
    check({tag, ".valid8"}, {63'h0, valid8_o},  {63'h0, sz > 0});
    check({tag, ".ready8"}, {63'h0, ready8_o},  {63'h0, sz < int'(PIPE_MAX_OCC)});
    check({tag, ".occ8"},   {62'h0, occ8_o},    64'(sz));
    check({tag, ".data8"},  {56'h0, data8_o},   exp8);
    check({tag, ".occ64"},  {62'h0, occ64_o},   64'(sz));
    check({tag, ".data64"}, data64_o,           exp64);
  endtask

  // Drive one cycle of inputs, clock it, advance the model, compare.
  task automatic step(input string tag, input logic v, input logic r,
                      input logic f, input logic [7:0] d);
    @(negedge tb_clk_i);
    valid_i  = v;
    ready_i  = r;
    flush_i  = f;
    data8_i  = d;
    data64_i = {$urandom(), $urandom()};
    @(posedge tb_clk_i);
    model_edge();
    #1;
    check_model(tag);
  endtask

  initial begin
    rst_i    = 1'b1;
    flush_i  = 1'b0;
    valid_i  = 1'b0;
    ready_i  = 1'b0;
    data8_i  = 8'h0;
    data64_i = 64'h0;
    model_clear();

    // Reset values.
    @(posedge tb_clk_i);
    #1;
    check("rst.valid", {63'h0, valid8_o}, 64'h0);
    check("rst.ready", {63'h0, ready8_o}, 64'h1);
    check("rst.data",  {56'h0, data8_o},  64'h0);
    check("rst.occ",   {62'h0, occ8_o},   64'h0);
    check("rst.data64", data64_o,         64'h0);
    @(negedge tb_clk_i);
    rst_i = 1'b0;

    // Pass-through at full rate.
    step("pt0", 1'b1, 1'b1, 1'b0, 8'h11);
    check("pt0.d", {56'h0, data8_o}, 64'h11);
    check("pt0.o", {62'h0, occ8_o},  64'h1);
    step("pt1", 1'b1, 1'b1, 1'b0, 8'h22);
    check("pt1.d", {56'h0, data8_o}, 64'h22);
    step("pt2", 1'b1, 1'b1, 1'b0, 8'h33);
    check("pt2.d", {56'h0, data8_o}, 64'h33);
    check("pt2.v", {63'h0, valid8_o}, 64'h1);
    check("pt2.r", {63'h0, ready8_o}, 64'h1);
    step("pt3", 1'b0, 1'b1, 1'b0, 8'h00);
    check("pt3.v", {63'h0, valid8_o}, 64'h0);

    // Back-pressure into the skid register.
    step("sk0", 1'b1, 1'b0, 1'b0, 8'h0A);
    step("sk1", 1'b1, 1'b0, 1'b0, 8'h0B);
    check("sk1.o", {62'h0, occ8_o},   64'h2);
    check("sk1.r", {63'h0, ready8_o}, 64'h0);
    check("sk1.d", {56'h0, data8_o},  64'h0A);
    step("sk2", 1'b0, 1'b1, 1'b0, 8'h00);
    check("sk2.d", {56'h0, data8_o},  64'h0B);
    check("sk2.o", {62'h0, occ8_o},   64'h1);
    step("sk3", 1'b0, 1'b1, 1'b0, 8'h00);
    check("sk3.o", {62'h0, occ8_o},   64'h0);
    check("sk3.v", {63'h0, valid8_o}, 64'h0);

    // Long stall in SKID with junk on the input.
    step("st0", 1'b1, 1'b0, 1'b0, 8'h0A);
    step("st1", 1'b1, 1'b0, 1'b0, 8'h0B);
    for (int i = 0; i < 10; i++) begin
      step("stall", 1'($urandom_range(0, 1)), 1'b0, 1'b0, 8'($urandom()));
      check("stall.d", {56'h0, data8_o},  64'h0A);
      check("stall.o", {62'h0, occ8_o},   64'h2);
    end
    step("st2", 1'b0, 1'b1, 1'b0, 8'h00);
    check("st2.d", {56'h0, data8_o}, 64'h0B);
    step("st3", 1'b0, 1'b1, 1'b0, 8'h00);

    // Flush from SKID with an item offered in the same cycle.
    step("fl0", 1'b1, 1'b0, 1'b0, 8'h0A);
    step("fl1", 1'b1, 1'b0, 1'b0, 8'h0B);
    step("fl2", 1'b1, 1'b0, 1'b1, 8'h0C);
    check("fl2.v", {63'h0, valid8_o}, 64'h0);
    check("fl2.d", {56'h0, data8_o},  64'h0);
    check("fl2.o", {62'h0, occ8_o},   64'h0);
    step("fl3", 1'b0, 1'b1, 1'b0, 8'h00);
    check("fl3.v", {63'h0, valid8_o}, 64'h0);

    // Asynchronous reset between clock edges while in SKID.
    step("ar0", 1'b1, 1'b0, 1'b0, 8'h0A);
    step("ar1", 1'b1, 1'b0, 1'b0, 8'h0B);
    @(negedge tb_clk_i);
    #2;
    rst_i = 1'b1;
    #1;
    check("ar.valid", {63'h0, valid8_o}, 64'h0);
    check("ar.ready", {63'h0, ready8_o}, 64'h1);
    check("ar.data",  {56'h0, data8_o},  64'h0);
    check("ar.occ",   {62'h0, occ8_o},   64'h0);
    check("ar.data64", data64_o,         64'h0);
    model_clear();
    @(negedge tb_clk_i);
    rst_i = 1'b0;
    step("ar2", 1'b1, 1'b1, 1'b0, 8'h5A);
    check("ar2.d", {56'h0, data8_o},  64'h5A);
    check("ar2.v", {63'h0, valid8_o}, 64'h1);

    // Random stress with occasional flushes.
    for (int i = 0; i < 1000; i++) begin
      step("rnd", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 63) == 0), 8'($urandom()));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
